// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the two-master memory arbiter: FSM state encoding, bus owner
// encoding and the starvation-counter width helper.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Width of a counter that must hold 0..limit inclusive.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Generic request/response memory channel. The same bundle is used for the
// two upstream masters (req/gnt handshake) and for the downstream slave bus,
// where req acts as s_valid and gnt as s_ready.
//   master modport: drives req/addr/we/wdata/wmask, receives gnt/rvalid/rdata
//   slave modport : the reverse
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic                  req;
  logic [ADDR_W-1:0]     addr;
  logic                  we;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, addr, we, wdata, wmask,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, wdata, wmask,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection. LSU has fixed priority unless the IFU has
// lost STARVE_LIMIT consecutive arbitrations, in which case the IFU wins.
// Ports:
//   i_ifu_req, i_lsu_req : request valids
//   i_starve_cnt         : consecutive IFU losses
//   o_valid              : at least one request present
//   o_owner              : selected master (meaningful when o_valid)
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             i_ifu_req,
  input  logic             i_lsu_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_valid,
  output owner_e           o_owner
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic w_ifu_forced;

  always_comb begin
    w_ifu_forced = i_ifu_req && (i_starve_cnt == LIMIT);
    o_valid      = i_ifu_req || i_lsu_req;
    o_owner      = (i_lsu_req && !w_ifu_forced) ? OWN_LSU : OWN_IFU;
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between the instruction fetch unit (master 0) and the
// load/store unit (master 1). One transaction is outstanding at a time: the
// winner is granted in IDLE, its payload is registered onto the slave bus in
// REQ, and the slave response is routed back to the owner in RESP.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ifu_bus    : IFU channel (read-only; its we/wdata/wmask are ignored)
//   lsu_bus    : LSU channel
//   mem_bus    : slave bus (req=s_valid, gnt=s_ready, rvalid=s_rvalid)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   ifu_bus,
  mem_arbiter_if.slave   lsu_bus,
  mem_arbiter_if.master  mem_bus
);

  localparam int unsigned      CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e                r_state;
  state_e                w_state_next;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic [CNT_W-1:0]      w_starve_next;
  owner_e                r_owner;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wmask;

  logic                  w_pick_valid;
  owner_e                w_pick_owner;
  logic                  w_grant;
  logic                  w_resp;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .i_ifu_req    (ifu_bus.req),
    .i_lsu_req    (lsu_bus.req),
    .i_starve_cnt (r_starve_cnt),
    .o_valid      (w_pick_valid),
    .o_owner      (w_pick_owner)
  );

  // Grant is combinational from IDLE; gated by rst_n so that no grant escapes
  // while reset is held and nothing can be captured.
  assign w_grant = rst_n && (r_state == IDLE) && w_pick_valid;
  assign w_resp  = (r_state == RESP) && mem_bus.rvalid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. s_ready outside REQ and s_rvalid outside RESP are ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_pick_valid)   w_state_next = REQ;
      REQ:     if (mem_bus.gnt)    w_state_next = RESP;
      RESP:    if (mem_bus.rvalid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ifu_bus.gnt    = w_grant && (w_pick_owner == OWN_IFU);
    lsu_bus.gnt    = w_grant && (w_pick_owner == OWN_LSU);
    ifu_bus.rvalid = w_resp && (r_owner == OWN_IFU);
    lsu_bus.rvalid = w_resp && (r_owner == OWN_LSU);
    // Read data is broadcast; rvalid alone qualifies it.
    ifu_bus.rdata  = mem_bus.rdata;
    lsu_bus.rdata  = mem_bus.rdata;
    mem_bus.req    = (r_state == REQ);
    mem_bus.we     = r_we;
    mem_bus.addr   = r_addr;
    mem_bus.wdata  = r_wdata;
    mem_bus.wmask  = r_wmask;
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts IDLE arbitrations the IFU asked for and lost.
  // Any IDLE cycle where the IFU wins or is not asking clears it.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_starve_next = r_starve_cnt;
    if (r_state == IDLE) begin
      if (ifu_bus.req && (w_pick_owner == OWN_LSU)) begin
        w_starve_next = (r_starve_cnt == LIMIT) ? r_starve_cnt : r_starve_cnt + 1'b1;
      end else begin
        w_starve_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload capture on grant; held stable through REQ until the slave accepts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_IFU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_grant) begin
      r_owner <= w_pick_owner;
      if (w_pick_owner == OWN_LSU) begin
        r_we    <= lsu_bus.we;
        r_addr  <= lsu_bus.addr;
        r_wdata <= lsu_bus.wdata;
        r_wmask <= lsu_bus.wmask;
      end else begin
        // IFU is fetch-only: force a read with an empty mask.
        r_we    <= 1'b0;
        r_addr  <= ifu_bus.addr;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a scoreboard of expected transactions:
// each grant pushes the expected slave request and response, each slave phase
// pops and compares. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifu_bus ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lsu_bus ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ifu_bus (ifu_bus),
    .lsu_bus (lsu_bus),
    .mem_bus (mem_bus)
  );

  typedef struct {
    logic        owner;  // 0 = IFU, 1 = LSU
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_bus.req    = 1'b0;
    ifu_bus.addr   = '0;
    ifu_bus.we     = 1'b0;
    ifu_bus.wdata  = '0;
    ifu_bus.wmask  = '0;
    lsu_bus.req    = 1'b0;
    lsu_bus.addr   = '0;
    lsu_bus.we     = 1'b0;
    lsu_bus.wdata  = '0;
    lsu_bus.wmask  = '0;
    mem_bus.gnt    = 1'b0;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata  = '0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_s_valid"}, mem_bus.req, 0);
    chk({tag, "_s_we"}, mem_bus.we, 0);
    chk({tag, "_s_addr"}, mem_bus.addr, 0);
    chk({tag, "_s_wdata"}, mem_bus.wdata, 0);
    chk({tag, "_s_wmask"}, mem_bus.wmask, 0);
    chk({tag, "_ifu_gnt"}, ifu_bus.gnt, 0);
    chk({tag, "_lsu_gnt"}, lsu_bus.gnt, 0);
    chk({tag, "_ifu_rvalid"}, ifu_bus.rvalid, 0);
    chk({tag, "_lsu_rvalid"}, lsu_bus.rvalid, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    sb.delete();
    #1;
    chk_outputs_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive requests in an IDLE cycle, check which grant fires, push expectation.
  task automatic arbitrate(input bit ireq, input logic [31:0] iaddr, input bit lreq,
                           input logic [31:0] laddr, input bit lwe, input logic [31:0] lwdata,
                           input logic [3:0] lwmask, input bit exp_lsu,
                           input logic [31:0] rdata, input string tag);
    txn_t t;
    @(negedge clk);
    mem_bus.rvalid = 1'b0;
    ifu_bus.req    = ireq;
    ifu_bus.addr   = iaddr;
    lsu_bus.req    = lreq;
    lsu_bus.addr   = laddr;
    lsu_bus.we     = lwe;
    lsu_bus.wdata  = lwdata;
    lsu_bus.wmask  = lwmask;
    #1;
    chk({tag, "_ifu_gnt"}, ifu_bus.gnt, !exp_lsu);
    chk({tag, "_lsu_gnt"}, lsu_bus.gnt, exp_lsu);
    chk({tag, "_idle_rvalid"}, {ifu_bus.rvalid, lsu_bus.rvalid}, 2'b00);
    chk({tag, "_idle_s_valid"}, mem_bus.req, 0);
    t.owner = exp_lsu;
    t.we    = exp_lsu ? lwe : 1'b0;
    t.addr  = exp_lsu ? laddr : iaddr;
    t.wdata = lwdata;
    t.wmask = lwmask;
    t.rdata = rdata;
    sb.push_back(t);
  endtask

  // Slave side: hold s_ready low for wait_cycles REQ cycles, then accept and
  // respond in the following cycle. spur raises s_rvalid throughout REQ.
  task automatic serve(input int wait_cycles, input bit spur, input string tag);
    txn_t t;
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 1, 0);
      return;
    end
    t = sb[0];
    for (int c = 0; c <= wait_cycles; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (t.owner) lsu_bus.req = 1'b0;
        else         ifu_bus.req = 1'b0;
      end
      mem_bus.gnt    = (c == wait_cycles);
      mem_bus.rvalid = spur;
      mem_bus.rdata  = 32'hBAD0_BAD0;
      #1;
      chk({tag, "_s_valid"}, mem_bus.req, 1);
      chk({tag, "_s_addr"}, mem_bus.addr, t.addr);
      chk({tag, "_s_we"}, mem_bus.we, t.we);
      if (t.we) begin
        chk({tag, "_s_wdata"}, mem_bus.wdata, t.wdata);
        chk({tag, "_s_wmask"}, mem_bus.wmask, t.wmask);
      end
      chk({tag, "_req_gnt"}, {ifu_bus.gnt, lsu_bus.gnt}, 2'b00);
      chk({tag, "_req_rvalid"}, {ifu_bus.rvalid, lsu_bus.rvalid}, 2'b00);
    end
    @(negedge clk);
    mem_bus.gnt    = 1'b0;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = t.rdata;
    #1;
    chk({tag, "_resp_s_valid"}, mem_bus.req, 0);
    chk({tag, "_resp_gnt"}, {ifu_bus.gnt, lsu_bus.gnt}, 2'b00);
    chk({tag, "_ifu_rvalid"}, ifu_bus.rvalid, !t.owner);
    chk({tag, "_lsu_rvalid"}, lsu_bus.rvalid, t.owner);
    if (!t.owner)    chk({tag, "_ifu_rdata"}, ifu_bus.rdata, t.rdata);
    else if (!t.we)  chk({tag, "_lsu_rdata"}, lsu_bus.rdata, t.rdata);
    void'(sb.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    do_reset("reset");

    // Single IFU fetch, slave ready immediately.
    arbitrate(1, 32'h8000_0000, 0, '0, 0, '0, '0, 0, 32'h0000_0413, "fetch");
    serve(0, 0, "fetch");

    // Simultaneous requests: LSU write wins, waiting IFU granted at next IDLE.
    arbitrate(1, 32'h8000_0004, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 1, '0, "both");
    serve(0, 0, "lsu_wr");
    arbitrate(1, 32'h8000_0004, 0, '0, 0, '0, '0, 0, 32'h0000_0013, "ifu_after");
    serve(0, 0, "ifu_after");

    // Starvation: four LSU wins, fifth goes to IFU, then counter is cleared.
    do_reset("reset_starve");
    for (int i = 0; i < 4; i++) begin
      arbitrate(1, 32'h8000_0100, 1, 32'h8000_2000 + 32'(i * 4), 0, '0, '0, 1,
                32'h1000 + 32'(i), "starve_lsu");
      serve(0, 0, "starve_lsu");
    end
    arbitrate(1, 32'h8000_0100, 1, 32'h8000_2010, 0, '0, '0, 0, 32'h0000_0093, "starve_ifu");
    serve(0, 0, "starve_ifu");
    arbitrate(1, 32'h8000_0104, 1, 32'h8000_2014, 0, '0, '0, 1, 32'h2222_0000, "starve_clr");
    serve(0, 0, "starve_clr");

    // Slave back-pressure: s_ready low for 3 cycles while IFU waits.
    do_reset("reset_bp");
    arbitrate(1, 32'h8000_0200, 1, 32'h8000_3000, 0, '0, '0, 1, 32'h5555_AAAA, "bp_lsu");
    serve(3, 0, "bp_lsu");
    arbitrate(1, 32'h8000_0200, 0, '0, 0, '0, '0, 0, 32'h0000_0513, "bp_ifu");
    serve(0, 0, "bp_ifu");

    // Reset asserted while in RESP: outputs clear at once, no rvalid issued.
    arbitrate(1, 32'h8000_0300, 0, '0, 0, '0, '0, 0, 32'h0000_0667, "rst_mid");
    @(negedge clk);
    ifu_bus.req = 1'b0;
    mem_bus.gnt = 1'b1;
    #1;
    chk("rst_mid_s_valid", mem_bus.req, 1);
    @(negedge clk);
    mem_bus.gnt  = 1'b0;
    rst_n        = 1'b0;
    ifu_bus.req  = 1'b1;  // request held during reset must not be granted
    ifu_bus.addr = 32'h8000_0400;
    #1;
    chk_outputs_zero("rst_mid");
    void'(sb.pop_front());
    @(negedge clk);
    #1;
    chk("rst_mid_hold_rvalid", {ifu_bus.rvalid, lsu_bus.rvalid}, 2'b00);
    chk("rst_mid_hold_gnt", ifu_bus.gnt, 0);
    ifu_bus.req = 1'b0;
    rst_n       = 1'b1;
    arbitrate(1, 32'h8000_0400, 0, '0, 0, '0, '0, 0, 32'h0000_0737, "after_rst");
    serve(0, 0, "after_rst");

    // Spurious s_rvalid in IDLE and throughout REQ.
    @(negedge clk);
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'hFFFF_FFFF;
    #1;
    chk("spur_idle_rvalid", {ifu_bus.rvalid, lsu_bus.rvalid}, 2'b00);
    chk("spur_idle_s_valid", mem_bus.req, 0);
    arbitrate(0, '0, 1, 32'h8000_4000, 0, '0, '0, 1, 32'hCAFE_F00D, "spur");
    serve(2, 1, "spur");

    @(negedge clk);
    mem_bus.rvalid = 1'b0;
    #1;
    chk("end_rvalid", {ifu_bus.rvalid, lsu_bus.rvalid}, 2'b00);
    chk("end_scoreboard", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
